beta_decode: RTL and testbench
==============================

Name: beta_decode

Overview:
- Registered instruction-decode stage for the Beta CPU.
- Accepts a fetched instruction word plus PC over a valid/ready handshake.
- Decodes it into the datapath control bundle, including the 6-bit ALU function code consumed by the ALU, and presents the result over a downstream valid/ready handshake.
- Sits between fetch and register-read/execute. Flags illegal opcodes as ILLOP traps.

Parameters:
- XP_REG, 30, register index written with PC+4 on an illegal-opcode trap.
- LIT_W, 16, literal field width; sign-extended to 32 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous kill of all held instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  instruction word: op[31:26], rc[25:21], ra[20:16], rb[15:11], lit[15:0].
- in_pc  input  32  PC of in_instr.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_pc  output  32  registered in_pc.
- alu_fn  output  6  ALU function code.
- ra_addr  output  5  read port 1 address.
- rb_addr  output  5  read port 2 address: rc for ST, else rb.
- wa_addr  output  5  write address: XP_REG on illegal, else rc.
- literal  output  32  sign-extended lit.
- bsel  output  1  1 = ALU b operand is literal.
- werf  output  1  register-file write enable.
- wdsel  output  2  writeback source: 00 PC+4, 01 ALU, 10 memory.
- mwr  output  1  memory write.
- moe  output  1  memory read.
- pcsel  output  3  000 PC+4, 001 branch, 010 JMP, 011 ILLOP.
- br_ne  output  1  branch taken condition: 0 = BEQ (ra==0), 1 = BNE.
- illegal  output  1  opcode not implemented.

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, skid empty; all bundle outputs 0.
- Reset mid-transfer drops held instructions. in_ready=0 during reset.
- Capture: on in_valid && in_ready, decode in_instr and register the bundle.
  - out_valid=1 the next cycle; latency exactly 1 cycle.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Base in_ready = out_ready || !out_valid (combinational).
- Simultaneous out handshake and in capture: the new bundle replaces the old one in the same edge, with no bubble.
- flush=1: next edge out_valid=0, skid cleared. in_ready=0 while flush=1. Flush overrides capture and reset-free state.
- ALU function codes:
  - ADD/LD/ST/LDR 0x10, SUB 0x11
  - CMPEQ 0x03, CMPLT 0x05, CMPLE 0x07
  - AND 0x28, OR 0x2E, XOR 0x26, XNOR 0x29
  - SHL 0x30, SHR 0x31, SRA 0x33
- Opcode map:
  - Register-form ALU ops 0x20-0x2E: bsel=0, werf=1, wdsel=01.
  - Literal forms 0x30-0x3E: same as register forms, but bsel=1.
  - LD 0x18: bsel=1, moe=1, wdsel=10, werf=1.
  - ST 0x19: bsel=1, mwr=1, werf=0, rb_addr=rc.
  - JMP 0x1B: pcsel=010, wdsel=00, werf=1.
  - BEQ 0x1C / BNE 0x1D: pcsel=001, wdsel=00, werf=1, br_ne=op[0].
  - LDR 0x1F: moe=1, wdsel=10, werf=1, bsel=1; alu_fn 0x10, PC-relative address formed downstream.
- Illegal: every other opcode, including MUL 0x22/0x32, DIV 0x23/0x33, 0x27/0x37, 0x2F/0x3F.
  - illegal=1, pcsel=011, werf=1, wdsel=00, wa_addr=XP_REG, mwr=0, moe=0, alu_fn=0x10.
- Decode fields that do not apply still show raw instruction bits; only the control outputs are forced.

Optional Feature:
- Macro DECODE_SKID_EN.
- Defined:
  - in_ready is a pure register: 1 when the skid buffer is empty.
  - One-entry skid holds the instruction accepted while the output stalls.
  - When out_ready returns, skid contents move to the output the following cycle; in_ready=1 again the cycle after the skid empties.
  - Order is preserved; no instruction is dropped or duplicated.
  - flush clears both entries.
- Undefined: no skid; combinational in_ready as above.

Test Plan:
- Reset: rst_n=0 two cycles with in_valid=1, in_instr=0x80611000 -> out_valid=0, illegal=0, all bundle fields 0, in_ready=0.
- ADD(r1,r2,r3): in_instr 0x80611000, pc 0x100 -> one cycle later:
  - alu_fn=0x10, ra=1, rb=2, wa=3, bsel=0, werf=1, wdsel=01, pcsel=000, out_pc=0x100.
- CMPLTC(r5,-1,r4): in_instr 0xD485FFFF -> alu_fn=0x05, bsel=1, literal=0xFFFFFFFF, wa=4.
- ST: in_instr 0x6462000C -> mwr=1, werf=0, rb_addr=3, literal=0x0000000C, alu_fn=0x10.
- MUL: in_instr 0x88611000 -> illegal=1, pcsel=011, wa=30, werf=1, wdsel=00, mwr=0.
- Backpressure + flush:
  - Hold out_ready=0 for 3 cycles with BNE 0x7401FFFE valid -> outputs stable; pcsel=001, br_ne=1.
  - Then assert flush -> out_valid=0 next cycle.
  - With DECODE_SKID_EN: a second instruction is accepted during the stall; after releasing out_ready both emerge in order.

Source files
------------

// File: rtl/beta_decode.sv
// Registered Beta instruction-decode stage with valid/ready handshakes on both sides.
// Optional one-entry skid buffer with a registered in_ready: define DECODE_SKID_EN.
module beta_decode #(
   parameter int XP_REG = 30,
   parameter int LIT_W  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [5:0]  alu_fn,
   output logic [4:0]  ra_addr,
   output logic [4:0]  rb_addr,
   output logic [4:0]  wa_addr,
   output logic [31:0] literal,
   output logic        bsel,
   output logic        werf,
   output logic [1:0]  wdsel,
   output logic        mwr,
   output logic        moe,
   output logic [2:0]  pcsel,
   output logic        br_ne,
   output logic        illegal
);

   // Handshake: a transfer happens on a rising edge where valid && ready; a
   // producer holds valid and its payload stable until that edge.

   typedef struct packed {
      logic [31:0] pc;
      logic [5:0]  alu_fn;
      logic [4:0]  ra_addr;
      logic [4:0]  rb_addr;
      logic [4:0]  wa_addr;
      logic [31:0] literal;
      logic        bsel;
      logic        werf;
      logic [1:0]  wdsel;
      logic        mwr;
      logic        moe;
      logic [2:0]  pcsel;
      logic        br_ne;
      logic        illegal;
   } bundle_t;

   logic [5:0] op;
   logic [5:0] alu_code;
   logic       alu_ok;
   bundle_t    dec;
   bundle_t    out_q;
   logic       out_valid_q;

   assign op = in_instr[31:26];

   // Low nibble of a register/literal ALU opcode selects the ALU operation.
   always_comb begin
      alu_code = 6'h10;
      alu_ok   = 1'b1;
      case (op[3:0])
         4'h0:    alu_code = 6'h10;
         4'h1:    alu_code = 6'h11;
         4'h4:    alu_code = 6'h03;
         4'h5:    alu_code = 6'h05;
         4'h6:    alu_code = 6'h07;
         4'h8:    alu_code = 6'h28;
         4'h9:    alu_code = 6'h2E;
         4'hA:    alu_code = 6'h26;
         4'hB:    alu_code = 6'h29;
         4'hC:    alu_code = 6'h30;
         4'hD:    alu_code = 6'h31;
         4'hE:    alu_code = 6'h33;
         default: alu_ok   = 1'b0;
      endcase
   end

   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.alu_fn  = 6'h10;
      dec.ra_addr = in_instr[20:16];
      dec.rb_addr = in_instr[15:11];
      dec.wa_addr = in_instr[25:21];
      dec.literal = {{(32-LIT_W){in_instr[LIT_W-1]}}, in_instr[LIT_W-1:0]};
      case (op)
         6'h18: begin
            dec.bsel  = 1'b1;
            dec.moe   = 1'b1;
            dec.wdsel = 2'b10;
            dec.werf  = 1'b1;
         end
         6'h19: begin
            dec.bsel    = 1'b1;
            dec.mwr     = 1'b1;
            dec.rb_addr = in_instr[25:21];
         end
         6'h1B: begin
            dec.pcsel = 3'b010;
            dec.werf  = 1'b1;
         end
         6'h1C, 6'h1D: begin
            dec.pcsel = 3'b001;
            dec.werf  = 1'b1;
            dec.br_ne = op[0];
         end
         6'h1F: begin
            dec.bsel  = 1'b1;
            dec.moe   = 1'b1;
            dec.wdsel = 2'b10;
            dec.werf  = 1'b1;
         end
         default: begin
            if (op[5] && alu_ok) begin
               dec.alu_fn = alu_code;
               dec.bsel   = op[4];
               dec.werf   = 1'b1;
               dec.wdsel  = 2'b01;
            end else begin
               dec.illegal = 1'b1;
               dec.pcsel   = 3'b011;
               dec.werf    = 1'b1;
               dec.wa_addr = 5'(XP_REG);
            end
         end
      endcase
   end

`ifdef DECODE_SKID_EN
   bundle_t skid_q;
   logic    skid_valid_q;
   logic    in_ready_q;
   logic    accept;
   logic    skid_valid_next;

   assign accept   = in_valid && in_ready_q && !flush;
   assign in_ready = in_ready_q;

   // A full skid implies a valid output, so it drains only through the output.
   assign skid_valid_next = skid_valid_q ? !out_ready
                                         : (accept && out_valid_q && !out_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         in_ready_q   <= 1'b0;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
               out_q       <= skid_q;
               out_valid_q <= 1'b1;
            end else if (accept) begin
               out_q       <= dec;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_q <= dec;
         end
         skid_valid_q <= skid_valid_next;
         in_ready_q   <= !skid_valid_next;
      end
   end
`else
   assign in_ready = rst_n && !flush && (out_ready || !out_valid_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid_q <= 1'b1;
         out_q       <= dec;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign out_pc    = out_q.pc;
   assign alu_fn    = out_q.alu_fn;
   assign ra_addr   = out_q.ra_addr;
   assign rb_addr   = out_q.rb_addr;
   assign wa_addr   = out_q.wa_addr;
   assign literal   = out_q.literal;
   assign bsel      = out_q.bsel;
   assign werf      = out_q.werf;
   assign wdsel     = out_q.wdsel;
   assign mwr       = out_q.mwr;
   assign moe       = out_q.moe;
   assign pcsel     = out_q.pcsel;
   assign br_ne     = out_q.br_ne;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_beta_decode.sv
// Self-checking bench for beta_decode: directed test-plan cases plus random
// traffic checked against a table-driven opcode model and an expected queue.
`timescale 1ns/1ps
module tb_beta_decode;
   localparam int W = 96;
   localparam int K_ILL = 0, K_ALUR = 1, K_ALUL = 2, K_LD = 3, K_ST = 4,
                  K_JMP = 5, K_BR = 6, K_LDR = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, literal;
   logic [5:0]  alu_fn;
   logic [4:0]  ra_addr, rb_addr, wa_addr;
   logic        bsel, werf, mwr, moe, br_ne, illegal;
   logic [1:0]  wdsel;
   logic [2:0]  pcsel;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [W-1:0] exp_q[$];
   int          kind_tab[64];
   logic [5:0]  fn_tab[64];
   int          legal_ops[$];

   always #5 clk = ~clk;

   beta_decode dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .alu_fn(alu_fn), .ra_addr(ra_addr), .rb_addr(rb_addr), .wa_addr(wa_addr),
      .literal(literal), .bsel(bsel), .werf(werf), .wdsel(wdsel), .mwr(mwr),
      .moe(moe), .pcsel(pcsel), .br_ne(br_ne), .illegal(illegal)
   );

   wire [W-1:0] dut_b = {out_pc, alu_fn, ra_addr, rb_addr, wa_addr, literal,
                         bsel, werf, wdsel, mwr, moe, pcsel, br_ne, illegal};

   task automatic init_tables();
      logic [5:0] codes[16];
      bit         impl[16];
      codes = '{6'h10, 6'h11, 6'h00, 6'h00, 6'h03, 6'h05, 6'h07, 6'h00,
                6'h28, 6'h2E, 6'h26, 6'h29, 6'h30, 6'h31, 6'h33, 6'h00};
      impl  = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
      for (int i = 0; i < 64; i++) begin
         kind_tab[i] = K_ILL;
         fn_tab[i]   = 6'h10;
      end
      for (int i = 0; i < 16; i++) begin
         if (impl[i]) begin
            kind_tab[32+i] = K_ALUR; fn_tab[32+i] = codes[i];
            kind_tab[48+i] = K_ALUL; fn_tab[48+i] = codes[i];
         end
      end
      kind_tab[24] = K_LD;  kind_tab[25] = K_ST;  kind_tab[27] = K_JMP;
      kind_tab[28] = K_BR;  kind_tab[29] = K_BR;  kind_tab[31] = K_LDR;
      for (int i = 0; i < 64; i++) if (kind_tab[i] != K_ILL) legal_ops.push_back(i);
   endtask

   // Expected bundle from the instruction-class table.
   function automatic logic [W-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
      logic [5:0]  o, fn;
      logic [4:0]  ra, rb, wa;
      logic [31:0] lit;
      logic        b, we, mw, mo, bn, il;
      logic [1:0]  wd;
      logic [2:0]  ps;
      o  = ins[31:26];
      ra = ins[20:16]; rb = ins[15:11]; wa = ins[25:21];
      lit = {{16{ins[15]}}, ins[15:0]};
      fn = 6'h10; b = 0; we = 0; mw = 0; mo = 0; bn = 0; il = 0; wd = 2'b00; ps = 3'b000;
      case (kind_tab[o])
         K_ALUR: begin fn = fn_tab[o]; we = 1; wd = 2'b01; end
         K_ALUL: begin fn = fn_tab[o]; we = 1; wd = 2'b01; b = 1; end
         K_LD:   begin b = 1; mo = 1; wd = 2'b10; we = 1; end
         K_ST:   begin b = 1; mw = 1; rb = wa; end
         K_JMP:  begin ps = 3'b010; we = 1; end
         K_BR:   begin ps = 3'b001; we = 1; bn = o[0]; end
         K_LDR:  begin b = 1; mo = 1; wd = 2'b10; we = 1; end
         default: begin il = 1; ps = 3'b011; we = 1; wa = 5'd30; end
      endcase
      return {pc, fn, ra, rb, wa, lit, b, we, wd, mw, mo, ps, bn, il};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] o;
      if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(0, 63));
      else o = 6'(legal_ops[$urandom_range(0, legal_ops.size() - 1)]);
      return {o, 26'($urandom())};
   endfunction

   // Driver: present one instruction for one edge with out_ready high.
   task automatic exec_one(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h80611000; in_pc = 32'h100; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      n_checks++; if (dut_b !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", dut_b); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      in_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      // Reset while a bundle is held drops it.
      exec_one(32'h80611000, 32'h100);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL premid_valid: got %b want 1", out_valid); end
      out_ready = 1'b0; rst_n = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
      n_checks++; if (dut_b !== '0) begin n_fail++; $display("FAIL midreset_bundle: got %h want 0", dut_b); end
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_instr = 32'h80611000; in_pc = 32'h100; out_ready = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_pre_valid: got %b want 0", out_valid); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
      n_checks++; if ({alu_fn, ra_addr, rb_addr, wa_addr} !== {6'h10, 5'd1, 5'd2, 5'd3}) begin n_fail++;
         $display("FAIL add_fields: got fn=%h ra=%0d rb=%0d wa=%0d want fn=10 ra=1 rb=2 wa=3", alu_fn, ra_addr, rb_addr, wa_addr); end
      n_checks++; if ({bsel, werf, wdsel, pcsel} !== {1'b0, 1'b1, 2'b01, 3'b000}) begin n_fail++;
         $display("FAIL add_ctrl: got bsel=%b werf=%b wdsel=%b pcsel=%b want 0 1 01 000", bsel, werf, wdsel, pcsel); end
      n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL add_pc: got %h want 00000100", out_pc); end
      n_checks++; if (dut_b !== model(32'h80611000, 32'h100)) begin n_fail++;
         $display("FAIL add_bundle: got %h want %h", dut_b, model(32'h80611000, 32'h100)); end
   endtask

   task automatic test_literal_and_store();
      exec_one(32'hD485FFFF, 32'h104);
      n_checks++; if ({alu_fn, bsel, wa_addr} !== {6'h05, 1'b1, 5'd4}) begin n_fail++;
         $display("FAIL cmpltc_fields: got fn=%h bsel=%b wa=%0d want fn=05 bsel=1 wa=4", alu_fn, bsel, wa_addr); end
      n_checks++; if (literal !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cmpltc_lit: got %h want ffffffff", literal); end
      exec_one(32'h6462000C, 32'h108);
      n_checks++; if ({mwr, werf, rb_addr, alu_fn} !== {1'b1, 1'b0, 5'd3, 6'h10}) begin n_fail++;
         $display("FAIL st_fields: got mwr=%b werf=%b rb=%0d fn=%h want 1 0 3 10", mwr, werf, rb_addr, alu_fn); end
      n_checks++; if (literal !== 32'h0000000C) begin n_fail++; $display("FAIL st_lit: got %h want 0000000c", literal); end
      n_checks++; if (dut_b !== model(32'h6462000C, 32'h108)) begin n_fail++;
         $display("FAIL st_bundle: got %h want %h", dut_b, model(32'h6462000C, 32'h108)); end
   endtask

   task automatic test_illegal();
      exec_one(32'h88611000, 32'h10C);
      n_checks++; if ({illegal, pcsel, wa_addr} !== {1'b1, 3'b011, 5'd30}) begin n_fail++;
         $display("FAIL mul_trap: got ill=%b pcsel=%b wa=%0d want 1 011 30", illegal, pcsel, wa_addr); end
      n_checks++; if ({werf, wdsel, mwr, moe, alu_fn} !== {1'b1, 2'b00, 1'b0, 1'b0, 6'h10}) begin n_fail++;
         $display("FAIL mul_ctrl: got werf=%b wdsel=%b mwr=%b moe=%b fn=%h want 1 00 0 0 10", werf, wdsel, mwr, moe, alu_fn); end
      n_checks++; if ({ra_addr, rb_addr} !== {5'd1, 5'd2}) begin n_fail++;
         $display("FAIL mul_raw: got ra=%0d rb=%0d want 1 2", ra_addr, rb_addr); end
   endtask

   task automatic test_backpressure_flush();
      logic [W-1:0] exp_bne;
      logic         exp_rdy;
      exp_bne = model(32'h7401FFFE, 32'h200);
      out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h7401FFFE; in_pc = 32'h200; out_ready = 1'b0;
      @(negedge clk);
`ifdef DECODE_SKID_EN
      in_instr = 32'h80611000; in_pc = 32'h204;
`else
      in_valid = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin
         #1;
`ifdef DECODE_SKID_EN
         exp_rdy = (i == 0);
`else
         exp_rdy = 1'b0;
`endif
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
         n_checks++; if (dut_b !== exp_bne) begin n_fail++; $display("FAIL hold_bundle[%0d]: got %h want %h", i, dut_b, exp_bne); end
         n_checks++; if ({pcsel, br_ne} !== {3'b001, 1'b1}) begin n_fail++;
            $display("FAIL hold_bne[%0d]: got pcsel=%b br_ne=%b want 001 1", i, pcsel, br_ne); end
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy); end
         @(negedge clk);
         in_valid = 1'b0;
      end
`ifdef DECODE_SKID_EN
      out_ready = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (dut_b !== model(32'h80611000, 32'h204) || out_valid !== 1'b1) begin n_fail++;
         $display("FAIL skid_second: got v=%b %h want v=1 %h", out_valid, dut_b, model(32'h80611000, 32'h204)); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready: got %b want 1", in_ready); end
      out_ready = 1'b0;
`endif
      flush = 1'b1; #1;
`ifndef DECODE_SKID_EN
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
`endif
      @(negedge clk); flush = 1'b0; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins, pc;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ins = rand_instr(); pc = 32'h300 + 32'(i * 4);
         in_valid = 1'b1; in_instr = ins; in_pc = pc;
         @(negedge clk); #1;
         n_checks++; if (out_valid !== 1'b1 || dut_b !== model(ins, pc)) begin n_fail++;
            $display("FAIL b2b[%0d]: got v=%b %h want v=1 %h", i, out_valid, dut_b, model(ins, pc)); end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random(input int n);
      logic [31:0] ins, pc;
      logic        fl, exp_rdy, m_rdy, in_fire, out_fire;
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_rdy = 1'b0;
      for (int c = 0; c < n; c++) begin
         ins = rand_instr(); pc = $urandom();
         fl = ($urandom_range(0, 31) == 0);
         in_valid = 1'($urandom_range(0, 1)); in_instr = ins; in_pc = pc;
         out_ready = ($urandom_range(0, 3) != 0); flush = fl;
         #1;
`ifdef DECODE_SKID_EN
         exp_rdy = m_rdy;
`else
         exp_rdy = !fl && (out_ready || exp_q.size() == 0);
`endif
         n_checks++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++;
            $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            n_checks++; if (dut_b !== exp_q[0]) begin n_fail++; $display("FAIL rand_bundle[%0d]: got %h want %h", c, dut_b, exp_q[0]); end
         end
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy); end
         out_fire = (exp_q.size() != 0) && out_ready;
         in_fire  = in_valid && exp_rdy && !fl;
         @(negedge clk);
         if (fl) exp_q.delete();
         else begin
            if (out_fire) void'(exp_q.pop_front());
            if (in_fire) exp_q.push_back(model(ins, pc));
         end
         m_rdy = !fl && (exp_q.size() < 2);
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      init_tables();
      @(negedge clk);
      test_reset();
      test_add();
      test_literal_and_store();
      test_illegal();
      test_backpressure_flush();
      test_back_to_back();
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
